// File: rtl/float_pack.sv
// Shared float definitions: reduced and IEEE-754 single formats,
// float class enum and bias helpers.
package float_pack;

    localparam int N_mantisse = 20;
    localparam int N_exposant = 4;
    localparam int IEEE_BIAS  = 127;

    typedef struct packed {
        logic                  signe;
        logic [N_exposant-1:0] exposant;
        logic [N_mantisse-1:0] mantisse;
    } float;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_ieee;

    typedef enum logic [1:0] {
        FC_ZERO   = 2'd0,
        FC_NORMAL = 2'd1,
        FC_INF    = 2'd2
    } float_class_t;

    function automatic int float_bias();
        return (1 << (N_exposant - 1)) - 1;
    endfunction

endpackage

// File: rtl/float2ieee_stream_if.sv
// Valid/ready bundle for the reduced-float to IEEE converter:
// input word side, output word side and status outputs.
interface float2ieee_stream_if
    import float_pack::*;
#(
    parameter int N_MANT = N_mantisse,
    parameter int N_EXP  = N_exposant
);

    logic                    in_valid;
    logic                    in_ready;
    logic [N_EXP+N_MANT:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_data;
    logic                    out_zero;
    logic                    out_inf;
    logic [15:0]             out_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data,
        input  out_zero, out_inf, out_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data,
        output out_zero, out_inf, out_cnt
    );

endinterface

// File: rtl/float_class_decode.sv
// Classifies a reduced float by its exponent field; the mantissa
// plays no part in the class since NaN is never produced.
module float_class_decode
    import float_pack::*;
#(
    parameter int N_MANT = N_mantisse,
    parameter int N_EXP  = N_exposant
) (
    input  logic [N_EXP-1:0]  e,
    input  logic [N_MANT-1:0] m,
    output float_class_t      cls
);

    logic unused_mant;
    assign unused_mant = ^m;

    always_comb begin
        cls = FC_NORMAL;
        unique case (1'b1)
            (e == '0): cls = FC_ZERO;
            (&e):      cls = FC_INF;
            default:   cls = FC_NORMAL;
        endcase
    end

endmodule

// File: rtl/float2ieee_stream.sv
// Two-stage reduced-float to IEEE-754 single converter with valid/ready.
// Define FLOAT2IEEE_CNT_EN to enable the saturating transfer counter.
module float2ieee_stream
    import float_pack::*;
#(
    parameter int N_MANT = N_mantisse,
    parameter int N_EXP  = N_exposant
) (
    input  logic clk,
    input  logic reset_n,
    float2ieee_stream_if.slave bus
);

    localparam logic [8:0] EXP_OFS = 9'(IEEE_BIAS - float_bias());

    logic              adv;
    logic              in_sign;
    logic [N_EXP-1:0]  in_exp;
    logic [N_MANT-1:0] in_mant;
    float_class_t      in_cls;

    logic              s1_valid;
    logic              s1_sign;
    logic [N_EXP-1:0]  s1_exp;
    logic [N_MANT-1:0] s1_mant;
    float_class_t      s1_cls;

    float_ieee         asm_data;
    logic              asm_zero;
    logic              asm_inf;
    logic [8:0]        exp_wide;
    logic              unused_exp_msb;

    logic              out_valid_q;
    logic [31:0]       out_data_q;
    logic              out_zero_q;
    logic              out_inf_q;

    assign in_sign = bus.in_data[N_EXP+N_MANT];
    assign in_exp  = bus.in_data[N_MANT +: N_EXP];
    assign in_mant = bus.in_data[N_MANT-1:0];

    float_class_decode #(
        .N_MANT (N_MANT),
        .N_EXP  (N_EXP)
    ) u_decode (
        .e   (in_exp),
        .m   (in_mant),
        .cls (in_cls)
    );

    // Both stages move together; a stalled output freezes everything.
    always_comb begin
        adv          = !out_valid_q || bus.out_ready;
        bus.in_ready = adv;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_cls   <= FC_ZERO;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_sign  <= in_sign;
            s1_exp   <= in_exp;
            s1_mant  <= in_mant;
            s1_cls   <= in_cls;
        end
    end

    always_comb begin
        asm_data = '0;
        asm_zero = 1'b0;
        asm_inf  = 1'b0;
        exp_wide = 9'(s1_exp) + EXP_OFS;
        asm_data.sign = s1_sign;
        unique case (s1_cls)
            FC_ZERO: begin
                asm_zero = 1'b1;
            end
            FC_INF: begin
                asm_data.exp = 8'hFF;
                asm_inf      = 1'b1;
            end
            default: begin
                asm_data.exp  = exp_wide[7:0];
                asm_data.mant = 23'(s1_mant) << (23 - N_MANT);
            end
        endcase
    end

    assign unused_exp_msb = exp_wide[8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
            out_inf_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= s1_valid;
            out_data_q  <= asm_data;
            out_zero_q  <= asm_zero;
            out_inf_q   <= asm_inf;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_inf   = out_inf_q;

`ifdef FLOAT2IEEE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (out_valid_q && bus.out_ready && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.out_cnt = cnt_q;
`else
    assign bus.out_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_float2ieee_stream.sv
// Directed-vector bench for float2ieee_stream (N_EXP=4, N_MANT=20):
// conversions, stalled streaming, counter and asynchronous reset.
module tb_float2ieee_stream;
    import float_pack::*;

    localparam int N_MANT = 20;
    localparam int N_EXP  = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   passed  = 0;
    int   total   = 0;

    float2ieee_stream_if #(.N_MANT(N_MANT), .N_EXP(N_EXP)) bus ();

    float2ieee_stream #(
        .N_MANT (N_MANT),
        .N_EXP  (N_EXP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        #12;
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        else passed++;
        total++;
        if (bus.out_data !== 32'h0)
            $display("FAIL reset_out_data: got %h expected 00000000", bus.out_data);
        else passed++;
        total++;
        if (bus.out_zero !== 1'b0 || bus.out_inf !== 1'b0)
            $display("FAIL reset_flags: got %b%b expected 00", bus.out_zero, bus.out_inf);
        else passed++;
        total++;
        if (bus.out_cnt !== 16'h0)
            $display("FAIL reset_out_cnt: got %h expected 0000", bus.out_cnt);
        else passed++;
        total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_convert();
        logic [24:0] vin  [6];
        logic [31:0] vexp [6];
        logic        vz   [6];
        logic        vi   [6];
        vin[0] = {1'b0, 4'd7,  20'h00000}; vexp[0] = 32'h3F800000; vz[0] = 0; vi[0] = 0;
        vin[1] = {1'b1, 4'd8,  20'h40000}; vexp[1] = 32'hC0200000; vz[1] = 0; vi[1] = 0;
        vin[2] = {1'b0, 4'd0,  20'h00000}; vexp[2] = 32'h00000000; vz[2] = 1; vi[2] = 0;
        vin[3] = {1'b1, 4'd0,  20'h12345}; vexp[3] = 32'h80000000; vz[3] = 1; vi[3] = 0;
        vin[4] = {1'b0, 4'd14, 20'hFFFFF}; vexp[4] = 32'h437FFFF8; vz[4] = 0; vi[4] = 0;
        vin[5] = {1'b0, 4'd15, 20'hABCDE}; vexp[5] = 32'h7F800000; vz[5] = 0; vi[5] = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_data   = vin[i];
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b1)
                $display("FAIL conv%0d_valid: got %b expected 1", i, bus.out_valid);
            else passed++;
            total++;
            if (bus.out_data !== vexp[i])
                $display("FAIL conv%0d_data: got %h expected %h", i, bus.out_data, vexp[i]);
            else passed++;
            total++;
            if (bus.out_zero !== vz[i])
                $display("FAIL conv%0d_zero: got %b expected %b", i, bus.out_zero, vz[i]);
            else passed++;
            total++;
            if (bus.out_inf !== vi[i])
                $display("FAIL conv%0d_inf: got %b expected %b", i, bus.out_inf, vi[i]);
            else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [24:0] win  [8];
        logic [31:0] wexp [8];
        logic [31:0] held;
        logic        holding;
        logic        exp_rdy;
        logic [15:0] exp_cnt;
        int          sent;
        int          got;
        int          cyc;
        win[0] = {1'b0, 4'd1,  20'h00000}; wexp[0] = 32'h3C800000;
        win[1] = {1'b1, 4'd2,  20'h80000}; wexp[1] = 32'hBD400000;
        win[2] = {1'b0, 4'd3,  20'h00001}; wexp[2] = 32'h3D800008;
        win[3] = {1'b0, 4'd0,  20'hFFFFF}; wexp[3] = 32'h00000000;
        win[4] = {1'b1, 4'd15, 20'h00000}; wexp[4] = 32'hFF800000;
        win[5] = {1'b0, 4'd6,  20'h12345}; wexp[5] = 32'h3F091A28;
        win[6] = {1'b1, 4'd5,  20'hFFFFF}; wexp[6] = 32'hBEFFFFF8;
        win[7] = {1'b0, 4'd8,  20'h00002}; wexp[7] = 32'h40000010;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        sent    = 0;
        got     = 0;
        cyc     = 0;
        holding = 1'b0;
        held    = '0;
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            bus.in_valid  = (sent < 8);
            bus.in_data   = (sent < 8) ? win[sent] : '0;
            #1;
            exp_rdy = !(bus.out_valid && !bus.out_ready);
            total++;
            if (bus.in_ready !== exp_rdy)
                $display("FAIL b2b_in_ready c%0d: got %b expected %b", cyc, bus.in_ready, exp_rdy);
            else passed++;
            if (holding) begin
                total++;
                if (bus.out_data !== held)
                    $display("FAIL b2b_stall_hold c%0d: got %h expected %h", cyc, bus.out_data, held);
                else passed++;
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (bus.out_data !== wexp[got])
                    $display("FAIL b2b_word%0d: got %h expected %h", got, bus.out_data, wexp[got]);
                else passed++;
                got++;
            end
            holding = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (bus.in_valid && bus.in_ready) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        total++;
        if (got != 8)
            $display("FAIL b2b_timeout: got %0d words expected 8", got);
        else passed++;
        @(posedge clk);
        #1;
`ifdef FLOAT2IEEE_CNT_EN
        exp_cnt = 16'd8;
`else
        exp_cnt = 16'd0;
`endif
        total++;
        if (bus.out_cnt !== exp_cnt)
            $display("FAIL b2b_out_cnt: got %0d expected %0d", bus.out_cnt, exp_cnt);
        else passed++;
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL b2b_drained: got %b expected 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_reset_inflight();
        int lat;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = {1'b1, 4'd8, 20'h40000};
        @(negedge clk);
        bus.in_data   = {1'b0, 4'd9, 20'h00000};
        @(negedge clk);
        bus.in_valid  = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1)
            $display("FAIL rst_setup_valid: got %b expected 1", bus.out_valid);
        else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL rst_async_valid: got %b expected 0", bus.out_valid);
        else passed++;
        total++;
        if (bus.out_data !== 32'h0)
            $display("FAIL rst_async_data: got %h expected 00000000", bus.out_data);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = {1'b0, 4'd7, 20'h00000};
        total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL rst_after_in_ready: got %b expected 1", bus.in_ready);
        else passed++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (lat < 6 && bus.out_valid !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        if (lat != 2)
            $display("FAIL rst_after_latency: got %0d expected 2", lat);
        else passed++;
        total++;
        if (bus.out_data !== 32'h3F800000)
            $display("FAIL rst_after_data: got %h expected 3f800000", bus.out_data);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_convert();
        test_back_to_back();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
